// File: rtl/counter_chain_pkg.sv
// counter_chain_pkg: FSM state encoding and default widths for the counter chain run controller.
package counter_chain_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSED, DONE} state_e;
   localparam int WRAP_W_DEF = 16;
   localparam int CYC_W_DEF = 32;
endpackage

// File: rtl/counter_chain_stats.sv
// counter_chain_stats: wrap counter and saturating enabled-cycle counter for one run.
module counter_chain_stats import counter_chain_pkg::*; #(
   parameter int WRAP_W = WRAP_W_DEF,
   parameter int CYC_W = CYC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              en_i,
   input  logic              tc_i,
   output logic [WRAP_W-1:0] wrap_count_o,
   output logic [CYC_W-1:0]  cycle_count_o
);
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   always_comb begin
      wrap_d = clear_i ? '0 : wrap_q + WRAP_W'(en_i && tc_i);
      cyc_d  = clear_i ? '0 : (en_i && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wrap_q <= '0;
         cyc_q  <= '0;
      end else begin
         wrap_q <= wrap_d;
         cyc_q  <= cyc_d;
      end
   end
   assign wrap_count_o  = wrap_q;
   assign cycle_count_o = cyc_q;
endmodule

// File: rtl/counter_chain_ctrl.sv
// counter_chain_ctrl: run controller that clears the chain, enables stage 0 until the commanded
// number of final-tc events, and reports completion; pause support requires CHAIN_CTRL_PAUSE_EN.
module counter_chain_ctrl import counter_chain_pkg::*; #(
   parameter int WRAP_W = WRAP_W_DEF,
   parameter int CYC_W = CYC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [WRAP_W-1:0] cmd_wraps,
   input  logic              abort,
   input  logic              pause,
   output logic              chain_clear,
   output logic              chain_enable,
   input  logic              chain_tc,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [CYC_W-1:0]  cycle_count
);
   state_e            state_q, state_d;
   logic [WRAP_W-1:0] target_q, target_d, wrap_inc;
   logic              en_q, busy_q, done_q, aborted_q, aborted_d, tc_hit;
`ifndef CHAIN_CTRL_PAUSE_EN
   logic unused_pause;
   assign unused_pause = pause;
`endif
   assign cmd_ready    = (state_q == IDLE) && !reset;
   assign chain_clear  = reset || (state_q == CLEAR);
   assign chain_enable = en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign tc_hit       = en_q && chain_tc;
   assign wrap_inc     = wrap_count + 1'b1;
   // Reaching the target wins over a same-cycle abort.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               target_d = cmd_wraps;
               state_d  = CLEAR;
            end
         end
         CLEAR: state_d = (target_q == '0) ? DONE : RUN;
         RUN: begin
            if (tc_hit && wrap_inc == target_q) state_d = DONE;
            else if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end
`ifdef CHAIN_CTRL_PAUSE_EN
            else if (pause) state_d = PAUSED;
`endif
         end
`ifdef CHAIN_CTRL_PAUSE_EN
         PAUSED: begin
            if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
            end else if (!pause) state_d = RUN;
         end
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         target_q  <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         en_q      <= state_d == RUN;
         busy_q    <= state_d inside {CLEAR, RUN, PAUSED};
         done_q    <= state_d == DONE;
         aborted_q <= aborted_d;
      end
   end
   counter_chain_stats #(.WRAP_W(WRAP_W), .CYC_W(CYC_W)) u_stats (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (state_q == CLEAR),
      .en_i         (en_q),
      .tc_i         (chain_tc),
      .wrap_count_o (wrap_count),
      .cycle_count_o(cycle_count)
   );
endmodule

// File: tb/tb_counter_chain_ctrl.sv
// tb_counter_chain_ctrl: directed bench for counter_chain_ctrl; a second instance with a 4-bit
// cycle counter shares the stimulus to show saturation. Pause checks follow CHAIN_CTRL_PAUSE_EN.
module tb_counter_chain_ctrl;
   logic        clk = 1'b0;
   logic        reset, cmd_valid, abort, pause, chain_tc;
   logic [15:0] cmd_wraps;
   logic        cmd_ready, chain_clear, chain_enable, busy, done, aborted;
   logic [15:0] wrap_count;
   logic [31:0] cycle_count;
   logic        r4, cl4, en4, b4, d4, a4;
   logic [15:0] w4;
   logic [3:0]  c4;
   int          vecs = 0, errs = 0, en;

   always #5 clk = ~clk;

   counter_chain_ctrl dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_wraps(cmd_wraps), .abort(abort), .pause(pause), .chain_clear(chain_clear),
      .chain_enable(chain_enable), .chain_tc(chain_tc), .busy(busy), .done(done),
      .aborted(aborted), .wrap_count(wrap_count), .cycle_count(cycle_count)
   );

   counter_chain_ctrl #(.WRAP_W(16), .CYC_W(4)) dut4 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(r4),
      .cmd_wraps(cmd_wraps), .abort(abort), .pause(pause), .chain_clear(cl4),
      .chain_enable(en4), .chain_tc(chain_tc), .busy(b4), .done(d4),
      .aborted(a4), .wrap_count(w4), .cycle_count(c4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start(input logic [15:0] w);
      chk("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_wraps = w;
      step();
      chk("clear_pulse", chain_clear, 1);
      chk("busy_clear", busy, 1);
      chk("ready_busy", cmd_ready, 0);
      chk("en_clear", chain_enable, 0);
      cmd_valid = 1'b0;
   endtask

   // Models the chain: one-cycle tc every `period` enabled cycles; optional abort on tc number abort_tc.
   task automatic run(input int period, input int abort_tc, output int n_en);
      int  tcs;
      bit  seen;
      n_en = 0;
      tcs  = 0;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         chain_tc = 1'b0;
         abort    = 1'b0;
         if (chain_enable) begin
            n_en++;
            if (n_en % period == 0) begin
               chain_tc = 1'b1;
               tcs++;
               abort = (tcs == abort_tc);
            end
         end
         step();
      end
      chain_tc = 1'b0;
      abort    = 1'b0;
      chk("done_seen", seen, 1);
      chk("en_low_done", chain_enable, 0);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_wraps = '0; abort = 1'b0; pause = 1'b0; chain_tc = 1'b0;
      step();
      step();
      chk("rst_clear", chain_clear, 1);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", chain_enable, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_wrap", wrap_count, 0);
      chk("rst_cyc", cycle_count, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_clear", chain_clear, 0);
      chk("post_rst_ready", cmd_ready, 1);
      step();
      // abort and pause in IDLE are ignored
      abort = 1'b1; pause = 1'b1;
      step();
      chk("idle_ignore_busy", busy, 0);
      chk("idle_ignore_done", done, 0);
      abort = 1'b0; pause = 1'b0;

      // basic run: 3 wraps, tc every 10 enabled cycles
      start(16'd3);
      run(10, 0, en);
      chk("basic_en_cycles", en, 30);
      chk("basic_aborted", aborted, 0);
      chk("basic_wrap", wrap_count, 3);
      chk("basic_cyc", cycle_count, 30);
      chk("basic_busy", busy, 0);
      chk("sat_cyc", c4, 15);
      chk("sat_wrap", w4, 3);
      chk("sat_done", d4, 1);
      step();
      chk("basic_done_pulse", done, 0);
      chk("basic_ready", cmd_ready, 1);
      chk("basic_wrap_hold", wrap_count, 3);
      chk("basic_cyc_hold", cycle_count, 30);

      // zero target
      start(16'd0);
      step();
      chk("zero_done", done, 1);
      chk("zero_en", chain_enable, 0);
      chk("zero_aborted", aborted, 0);
      chk("zero_wrap", wrap_count, 0);
      chk("zero_cyc", cycle_count, 0);
      step();
      chk("zero_done_pulse", done, 0);

      // abort with the 2nd tc of 5
      start(16'd5);
      run(4, 2, en);
      chk("abort2_aborted", aborted, 1);
      chk("abort2_wrap", wrap_count, 2);
      chk("abort2_cyc", cycle_count, 8);
      chk("abort2_sat_cyc", c4, 8);
      step();
      chk("abort2_aborted_clr", aborted, 0);

      // abort with the final tc: target reached wins
      start(16'd5);
      run(3, 5, en);
      chk("abort5_aborted", aborted, 0);
      chk("abort5_wrap", wrap_count, 5);
      chk("abort5_cyc", cycle_count, 15);
      step();

      // pause window of 7 cycles with tc held high (when paused)
      start(16'd2);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("pre_pause_en", chain_enable, 1);
         step();
      end
      pause = 1'b1;
      step();
`ifdef CHAIN_CTRL_PAUSE_EN
      chain_tc = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk("pause_en", chain_enable, 0);
         chk("pause_busy", busy, 1);
         chk("pause_cyc_hold", cycle_count, 5);
         chk("pause_wrap_hold", wrap_count, 0);
         if (i == 6) pause = 1'b0;
         step();
      end
      run(5, 0, en);
      chk("pause_wrap", wrap_count, 2);
      chk("pause_cyc", cycle_count, 15);
`else
      chain_tc = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("nopause_en", chain_enable, 1);
         if (i == 6) pause = 1'b0;
         step();
      end
      run(5, 0, en);
      chk("nopause_wrap", wrap_count, 2);
      chk("nopause_cyc", cycle_count, 22);
`endif
      chk("pause_aborted", aborted, 0);
      step();

      // synchronous reset mid-run
      start(16'd5);
      step(); step(); step();
      chk("mid_en", chain_enable, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_clear", chain_clear, 1);
      chk("mid_rst_ready", cmd_ready, 0);
      step();
      reset = 1'b0;
      #1;
      chk("mid_after_en", chain_enable, 0);
      chk("mid_after_busy", busy, 0);
      chk("mid_after_done", done, 0);
      chk("mid_after_wrap", wrap_count, 0);
      chk("mid_after_cyc", cycle_count, 0);
      chk("mid_after_ready", cmd_ready, 1);
      chk("mid_after_clear", chain_clear, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_no_done", done, 0);
      end

      // back-pressure: cmd_valid held through a whole run
      cmd_valid = 1'b1;
      cmd_wraps = 16'd1;
      chk("bp_ready0", cmd_ready, 1);
      step();
      chk("bp_clear", chain_clear, 1);
      step();
      chk("bp_ready_run1", cmd_ready, 0);
      step();
      chain_tc = 1'b1;
      chk("bp_ready_run2", cmd_ready, 0);
      step();
      chain_tc = 1'b0;
      chk("bp_done", done, 1);
      chk("bp_ready_done", cmd_ready, 0);
      chk("bp_wrap", wrap_count, 1);
      chk("bp_cyc", cycle_count, 2);
      step();
      chk("bp_ready_idle", cmd_ready, 1);
      chk("bp_idle_busy", busy, 0);
      step();
      chk("bp_reaccept", chain_clear, 1);
      chk("bp_reaccept_busy", busy, 1);
      cmd_valid = 1'b0;
      run(2, 0, en);
      chk("bp_run2_wrap", wrap_count, 1);
      chk("bp_run2_en", en, 2);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/counter_chain_ctrl.md
# counter_chain_ctrl

Run controller for the cascaded terminal-count counter chain. It accepts a run command through a valid/ready handshake and clears the chain. It then drives the stage-0 enable until the chain's final terminal count has fired a commanded number of times. It reports completion, abort status, wrap count and enabled-cycle count. It sits between the system control logic and the chain's shared `reset` and stage-0 `enable` inputs.

## Interface
- `WRAP_W`, 16: width of the commanded wrap target and of the wrap counter.
- `CYC_W`, 32: width of the enabled-cycle counter.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: run request.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_wraps` in WRAP_W: number of final-tc events to run for; sampled on accept.
- `abort` in 1: stop the run early.
- `pause` in 1: freeze the chain; honoured only with `CHAIN_CTRL_PAUSE_EN`.
- `chain_clear` out 1: drives the chain's shared `reset`.
- `chain_enable` out 1: drives the stage-0 `enable`.
- `chain_tc` in 1: terminal count of the last stage.
- `busy` out 1: high in CLEAR, RUN and PAUSED.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: valid with `done`; high when the run ended by abort.
- `wrap_count` out WRAP_W: final-tc events counted in the current or last run.
- `cycle_count` out CYC_W: cycles with `chain_enable` high; saturates at all-ones.

## Operation
- FSM states: IDLE, CLEAR, RUN, PAUSED, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - Handshake occurs on `cmd_valid && cmd_ready`: latch `cmd_wraps`, then go to CLEAR.
  - `cmd_valid` with `cmd_ready` low is held off and not dropped; the requester keeps it asserted.
- **CLEAR** (exactly 1 cycle)
  - `chain_clear` = 1; `wrap_count` and `cycle_count` are zeroed.
  - Target == 0: go to DONE with `aborted` = 0 and no enable cycles.
  - Otherwise go to RUN.
- **RUN**
  - `chain_enable` = 1; `cycle_count` increments every cycle.
  - `chain_tc` is counted only in cycles where `chain_enable` = 1.
  - On a counted tc: `wrap_count` += 1. If the new value equals the target, go to DONE.
  - `abort`: go to DONE with `aborted` = 1.
  - Abort and the final tc in the same cycle: the tc is counted and `aborted` = 0, because the target was reached.
  - `pause`: go to PAUSED. Abort has priority over pause.
- **PAUSED**
  - `chain_enable` = 0; `chain_tc` is ignored, since a stage may hold tc high while frozen; counters hold.
  - `pause` low: return to RUN. `abort`: go to DONE with `aborted` = 1.
- **DONE** (1 cycle)
  - `done` = 1, `aborted` valid; then go to IDLE.
- `wrap_count` and `cycle_count` hold their values after DONE until the next CLEAR.
- `abort` or `pause` seen in IDLE is ignored.

## Timing
- All state, counters and outputs are registered except the following:
  - `chain_clear` = `reset` OR (state == CLEAR), so the chain is cleared by global reset.
  - `cmd_ready` = (state == IDLE) AND NOT `reset`.
- Reset values:
  - state IDLE.
  - `chain_enable`, `busy`, `done` and `aborted` = 0.
  - `wrap_count` and `cycle_count` = 0.
  - `chain_clear` = 1 while reset is asserted.
- Command accepted in cycle 0: CLEAR in cycle 1; `chain_enable` high from cycle 2.
- Final tc counted in cycle t: `done` high and `chain_enable` low in cycle t+1.
- Abort sampled in cycle t: `chain_enable` low and `done` high in cycle t+1.
- Next command is accepted no earlier than the cycle after DONE.
- `reset` asserted mid-run: the next cycle is IDLE with all outputs at reset values; no `done` pulse.

## Configuration
- `CHAIN_CTRL_PAUSE_EN` defined: the `pause` input and the PAUSED state exist as described above.
- Not defined: `pause` is unconnected internally, PAUSED is not generated, and RUN proceeds uninterrupted.

## Structure
- Package `counter_chain_pkg` holds:
  - the state encoding constants (IDLE..DONE);
  - default `WRAP_W` and `CYC_W`.
- One sub-module, `counter_chain_stats`, contains the `wrap_count` and saturating `cycle_count` registers. Its controls are clear, enable and tc-qualify.

## Test plan
- **Basic run:** `cmd_wraps` = 3, chain_tc pulses 1 cycle every 10 enabled cycles → done at the cycle after the 3rd tc, `wrap_count` = 3, `cycle_count` = 30, `aborted` = 0.
- **Zero target:** `cmd_wraps` = 0 → 1 cycle of `chain_clear`, `done` the next cycle, `chain_enable` never high, `wrap_count` = 0.
- **Abort and tc race:**
  - `cmd_wraps` = 5, abort asserted with the 2nd tc → `done`, `aborted` = 1, `wrap_count` = 2.
  - Repeat with abort on the 5th tc → `aborted` = 0.
- **Pause (macro defined):** pause 7 cycles mid-run while chain_tc is held high → `chain_enable` low 7 cycles, no extra wraps, `cycle_count` excludes paused cycles.
- **Reset mid-run:** sync reset during RUN → next cycle IDLE, `chain_clear` high during reset, no `done`, `cmd_ready` high after reset deasserts.
- **Saturation and back-pressure:** `CYC_W` = 4 with a long run → `cycle_count` sticks at 15; `cmd_valid` held during busy → accepted only in the IDLE cycle after DONE.
